// File: rtl/layer1_out_pipe_pkg.sv
// Shared types and default widths for the layer-1 output pipeline stage.
package logicnets_pipe_pkg;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int STAT_W    = 16;
  localparam int DEF_IN_W  = 64;
  localparam int DEF_TAG_W = 8;

endpackage

// File: rtl/layer1_out_pipe_if.sv
// Valid/ready bundle between layer-1 neurons, the output stage and layer 2.
// slave: the pipeline stage side; master: the surrounding producer/consumer side.
interface layer1_out_pipe_if #(
  parameter int IN_W  = 64,
  parameter int TAG_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  s_data;
  logic             m_valid;
  logic             m_ready;
  logic [IN_W-1:0]  m_data;
  logic [TAG_W-1:0] m_tag;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_tag
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_tag
  );
endinterface

// File: rtl/layer1_out_pipe_reg.sv
// Enable register holding one {data, tag} word; used for the main and skid slots.
module layer_pipe_reg #(
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load only on enable so unaccepted input never reaches the held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/layer1_out_pipe.sv
// Two-entry skid buffer after the layer-1 LUT neurons. s_ready is a flop, so the
// upstream handshake never sees m_ready combinationally. Every accepted sample is
// tagged with a wrapping sequence number that travels with it.
// Optional: define LAYER_PIPE_STATS_EN to add the saturating stat_stall counter.
module layer1_out_pipe
  import logicnets_pipe_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  layer1_out_pipe_if.slave  pif
`ifdef LAYER_PIPE_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall
`endif
);

  localparam int W = IN_W + TAG_W;

  pipe_state_t      state_q, state_d;
  logic             s_ready_q;
  logic [TAG_W-1:0] tag_q;
  logic             acc_in, acc_out;
  logic             main_en, main_from_skid, skid_en;
  logic [W-1:0]     in_word, main_d, main_q, skid_q;

  assign acc_in  = pif.s_valid && s_ready_q;
  assign acc_out = (state_q != EMPTY) && pif.m_ready;
  assign in_word = {pif.s_data, tag_q};
  assign main_d  = main_from_skid ? skid_q : in_word;

  // Next occupancy and slot load enables from the two handshakes.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (acc_in) begin
          main_en = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (acc_in && !acc_out) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (acc_in && acc_out) begin
          main_en = 1'b1;
        end else if (acc_out) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // s_ready is low here, so nothing new can arrive in the same cycle.
        if (acc_out) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Occupancy, registered ready and sequence tag counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      s_ready_q <= 1'b1;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != FULL);
      if (acc_in) tag_q <= tag_q + 1'b1;
    end
  end

  layer_pipe_reg #(.W(W)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  layer_pipe_reg #(.W(W)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_word),
    .q   (skid_q)
  );

  assign pif.s_ready = s_ready_q;
  assign pif.m_valid = (state_q != EMPTY);
  assign pif.m_data  = main_q[W-1:TAG_W];
  assign pif.m_tag   = main_q[TAG_W-1:0];

`ifdef LAYER_PIPE_STATS_EN
  logic [STAT_W-1:0] stall_q;

  // Count back-pressure cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if ((state_q != EMPTY) && !pif.m_ready && (stall_q != {STAT_W{1'b1}}))
      stall_q <= stall_q + 1'b1;
  end

  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_layer1_out_pipe.sv
// Directed and randomized checks of the layer-1 output skid buffer against a queue model.
module tb_layer1_out_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  layer1_out_pipe_if #(.IN_W(64), .TAG_W(8)) pif ();

`ifdef LAYER_PIPE_STATS_EN
  logic [15:0] stat_stall;
`endif

  layer1_out_pipe #(.IN_W(64), .TAG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
`ifdef LAYER_PIPE_STATS_EN
    ,
    .stat_stall (stat_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  logic [63:0] q_data[$];
  logic [7:0]  q_tag[$];
  logic [7:0]  m_tagc;

  initial begin
    pif.s_valid = 1'b0;
    pif.s_data  = '0;
    pif.m_ready = 1'b0;

    // 1: reset state held while idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_sready", 64'(pif.s_ready), 64'd1);
      chk("rst_mvalid", 64'(pif.m_valid), 64'd0);
      chk("rst_mtag",   64'(pif.m_tag),   64'd0);
      chk("rst_mdata",  pif.m_data,       64'd0);
`ifdef LAYER_PIPE_STATS_EN
      chk("rst_stat",   64'(stat_stall),  64'd0);
`endif
    end

    // 2: streaming with m_ready=1, one cycle latency, no bubbles
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      pif.m_ready = 1'b1;
      pif.s_valid = 1'b1;
      pif.s_data  = 64'(i);
      @(negedge clk);
      chk("str_sready", 64'(pif.s_ready), 64'd1);
      if (i > 0) begin
        chk("str_mvalid", 64'(pif.m_valid), 64'd1);
        chk("str_mdata",  pif.m_data,       64'(i - 1));
        chk("str_mtag",   64'(pif.m_tag),   64'((i - 1) % 256));
      end
    end
    @(posedge clk);
    #1 pif.s_valid = 1'b0;
    @(negedge clk);
    chk("str_last_data", pif.m_data,     64'd299);
    chk("str_last_tag",  64'(pif.m_tag), 64'd43);

    // 3: fill to FULL with back-pressure, then drain in order
    @(posedge clk);
    #1;
    pif.m_ready = 1'b0;
    pif.s_valid = 1'b1;
    pif.s_data  = 64'hA;
    @(posedge clk);
    #1 pif.s_data = 64'hB;
    @(posedge clk);
    #1 pif.s_valid = 1'b0;
    @(negedge clk);
    chk("full_sready", 64'(pif.s_ready), 64'd0);
    chk("full_mvalid", 64'(pif.m_valid), 64'd1);
    chk("full_mdata",  pif.m_data,       64'hA);
    chk("full_mtag",   64'(pif.m_tag),   64'd44);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_mdata", pif.m_data,     64'hA);
      chk("hold_mtag",  64'(pif.m_tag), 64'd44);
    end
    @(posedge clk);
    #1 pif.m_ready = 1'b1;
    @(negedge clk);
    chk("drain_a",     pif.m_data,       64'hA);
    @(negedge clk);
    chk("drain_b",     pif.m_data,       64'hB);
    chk("drain_b_tag", 64'(pif.m_tag),   64'd45);
    chk("drain_sready",64'(pif.s_ready), 64'd1);
    @(negedge clk);
    chk("drain_empty", 64'(pif.m_valid), 64'd0);

    // 4: random handshakes against a FIFO model, ready must ignore m_ready
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_tagc = 8'd0;
    for (int c = 0; c < 3000; c++) begin
      logic        sv, mr, exp_rdy;
      logic [63:0] sd;
      @(posedge clk);
      #1;
      sv = 1'($urandom_range(0, 1));
      mr = 1'($urandom_range(0, 1));
      sd = {$urandom, $urandom};
      pif.s_valid = sv;
      pif.s_data  = sd;
      pif.m_ready = mr;
      @(negedge clk);
      exp_rdy = (q_data.size() < 2);
      chk("rnd_mvalid", 64'(pif.m_valid), 64'(q_data.size() > 0));
      chk("rnd_sready", 64'(pif.s_ready), 64'(exp_rdy));
      if (q_data.size() > 0) begin
        chk("rnd_mdata", pif.m_data,     q_data[0]);
        chk("rnd_mtag",  64'(pif.m_tag), 64'(q_tag[0]));
        if (mr) begin
          void'(q_data.pop_front());
          void'(q_tag.pop_front());
        end
      end
      if (sv && exp_rdy) begin
        q_data.push_back(sd);
        q_tag.push_back(m_tagc);
        m_tagc = m_tagc + 8'd1;
      end
      pif.m_ready = ~mr;
      #1;
      chk("rnd_sready_comb", 64'(pif.s_ready), 64'(exp_rdy));
      pif.m_ready = mr;
    end
    @(posedge clk);
    #1;
    pif.s_valid = 1'b0;
    pif.m_ready = 1'b1;
    for (int c = 0; c < 10 && q_data.size() > 0; c++) begin
      @(negedge clk);
      chk("rnd_drain_data", pif.m_data, q_data[0]);
      void'(q_data.pop_front());
      void'(q_tag.pop_front());
      @(posedge clk);
      #1;
    end
    chk("rnd_drain_left", 64'(q_data.size()), 64'd0);

    // 5: reset while FULL discards contents and restarts the tag
    @(posedge clk);
    #1;
    pif.m_ready = 1'b0;
    pif.s_valid = 1'b1;
    pif.s_data  = 64'h111;
    @(posedge clk);
    #1 pif.s_data = 64'h222;
    @(posedge clk);
    #1 pif.s_valid = 1'b0;
    @(negedge clk);
    chk("r5_full", 64'(pif.s_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("r5_mvalid", 64'(pif.m_valid), 64'd0);
    chk("r5_sready", 64'(pif.s_ready), 64'd1);
    @(posedge clk);
    #1;
    pif.m_ready = 1'b1;
    pif.s_valid = 1'b1;
    pif.s_data  = 64'h55;
    @(posedge clk);
    #1 pif.s_valid = 1'b0;
    @(negedge clk);
    chk("r5_new_valid", 64'(pif.m_valid), 64'd1);
    chk("r5_new_data",  pif.m_data,       64'h55);
    chk("r5_new_tag",   64'(pif.m_tag),   64'd0);

`ifdef LAYER_PIPE_STATS_EN
    // 6: stall counter saturates
    @(posedge clk);
    #1 pif.m_ready = 1'b0;
    pif.s_valid = 1'b1;
    pif.s_data  = 64'h77;
    @(posedge clk);
    #1 pif.s_valid = 1'b0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("stat_sat", 64'(stat_stall), 64'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
